regstat_file: RTL and testbench
===============================

# regstat_file

Parametrised architectural register file with per-register rename status (busy bit + ROB tag) for the out-of-order core. It sits between decode/issue, which reads source operands and renames destinations, and ROB commit, which writes retired results. Read ports are combinational, with same-cycle commit bypass. A flush clears all rename state on misprediction.

## Interface
- XLEN, 32, data width
- NREG, 32, number of registers (power of two, ≥2); AW = $clog2(NREG)
- TAG_W, 4, ROB tag width
- NRD, 2, number of read ports
- CW = $clog2(NREG+1), busy counter width (derived)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; when low, no state changes
- rd_addr  in  NRD*AW  read addresses, port k at [k*AW +: AW]
- rd_data  out  NRD*XLEN  read data per port
- rd_busy  out  NRD  register awaiting an in-flight result
- rd_tag  out  NRD*TAG_W  ROB tag producing the register (valid when rd_busy)
- ren_en  in  1  rename request (issue of instruction with destination)
- ren_addr  in  AW  destination register
- ren_tag  in  TAG_W  ROB tag assigned to destination
- cm_en  in  1  commit write
- cm_addr  in  AW  committed destination
- cm_tag  in  TAG_W  ROB tag of committing entry
- cm_data  in  XLEN  committed value
- flush  in  1  clear all rename state
- busy_cnt  out  CW  number of registers currently busy (registered)

## Operation
- State: data[NREG], busy[NREG], tag[NREG], busy_cnt.
- Register 0 is hardwired: reads return data 0, busy 0, tag 0; renames and commits to address 0 are ignored.
- Commit (cm_en, cm_addr≠0): data[cm_addr] ← cm_data. Busy clears only if busy[cm_addr] and tag[cm_addr]==cm_tag, with no rename to the same address this cycle.
- Rename (ren_en, ren_addr≠0, !flush): busy[ren_addr] ← 1, tag[ren_addr] ← ren_tag.
- Same-address rename and commit in one cycle: rename wins on busy/tag; the data write still occurs.
- Flush: all busy ← 0 and busy_cnt ← 0 at the edge. A same-cycle commit data write still applies. Same-cycle rename is dropped.
- busy_cnt update, incremental:
  - +1 when rename targets a non-busy register.
  - −1 when a commit clears busy.
  - Both at once: net 0.
  - Rename of an already-busy register with a same-cycle matching commit on that address: no change.
- Read port k (combinational, independent of rdy), priority:
  1. addr 0 → (0, 0, 0).
  2. Matching commit this cycle (cm_en, cm_addr==addr, busy, tag==cm_tag) → (cm_data, 0, tag).
  3. Non-matching commit to the same address → (cm_data, busy, tag).
  4. Otherwise → stored (data, busy, tag).
- A same-cycle rename is not visible to reads. Sources are read before the destination is renamed, which is correct for add x1,x1,x1.
- Same-cycle flush is not visible to reads.

## Timing
- Reset (rst low, asynchronous, dominates rdy): all data/busy/tag 0, busy_cnt 0, immediately and held while low. Deassertion is synchronous to clk per system reset synchroniser.
- rdy low: all inputs ignored at the edge; state and busy_cnt hold. Read outputs still reflect state plus the commit bypass.
- Rename/commit/flush take effect at the next rising edge. Read latency 0 cycles; busy_cnt lags by one edge.
- Rename with a tag equal to an in-flight tag for another register is legal. Tags are compared per register only.

## Test plan
- Reset: write x5=0xDEAD, assert rst low mid-cycle → x5 reads 0 immediately, busy_cnt 0 and all rd_busy 0.
- Rename x3 tag 7, then commit x3 tag 7 data 0x1234 → during the commit cycle the read of x3 gives 0x1234 busy 0; next cycle same, busy_cnt 1→0.
- Stale commit: rename x3 tag 2, rename x3 tag 5, commit x3 tag 2 data 0xAA → x3 data 0xAA, busy 1, tag 5, busy_cnt stays 1.
- Same-cycle rename x4 tag 9 with commit x4 tag 1 (matching old tag 1) data 0x77 → next cycle data 0x77, busy 1, tag 9, busy_cnt unchanged.
- Flush with 3 busy registers, plus a same-cycle commit x6=0x55 and rename x7 → all busy 0, busy_cnt 0, x6=0x55, x7 not busy.
- x0 and rdy: rename/commit x0=0xFF → reads 0/not busy. With rdy low, rename x8 → no change; busy_cnt 0.

Source files
------------

// File: rtl/regstat_if.sv
// Bundles the register-file read, rename, commit and flush signals between
// decode/issue, ROB commit and the register file.
interface regstat_if #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 4,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic                  rdy;
  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*XLEN-1:0]   rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [NRD*TAG_W-1:0]  rd_tag;
  logic                  ren_en;
  logic [AW-1:0]         ren_addr;
  logic [TAG_W-1:0]      ren_tag;
  logic                  cm_en;
  logic [AW-1:0]         cm_addr;
  logic [TAG_W-1:0]      cm_tag;
  logic [XLEN-1:0]       cm_data;
  logic                  flush;
  logic [CW-1:0]         busy_cnt;

  modport master (
    output rdy, rd_addr, ren_en, ren_addr, ren_tag,
           cm_en, cm_addr, cm_tag, cm_data, flush,
    input  rd_data, rd_busy, rd_tag, busy_cnt
  );

  modport slave (
    input  rdy, rd_addr, ren_en, ren_addr, ren_tag,
           cm_en, cm_addr, cm_tag, cm_data, flush,
    output rd_data, rd_busy, rd_tag, busy_cnt
  );
endinterface

// File: rtl/regstat_file.sv
// Architectural register file with per-register rename status (busy + ROB tag),
// combinational reads with same-cycle commit bypass, and flush of rename state.
module regstat_file #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 4,
  parameter int NRD   = 2
) (
  input logic       clk,
  input logic       rst,
  regstat_if.slave  bus
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic [XLEN-1:0]  data_q [NREG];
  logic [TAG_W-1:0] tag_q  [NREG];
  logic [NREG-1:0]  busy_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_next;

  logic ren_ok;
  logic cm_ok;
  logic cm_match;
  logic cm_clear;
  logic cnt_inc;

  assign ren_ok   = bus.rdy && bus.ren_en && (bus.ren_addr != '0) && !bus.flush;
  assign cm_ok    = bus.rdy && bus.cm_en && (bus.cm_addr != '0);
  assign cm_match = cm_ok && busy_q[bus.cm_addr] && (tag_q[bus.cm_addr] == bus.cm_tag);
  // A rename to the same register keeps it busy under the new tag.
  assign cm_clear = cm_match && !(ren_ok && (bus.ren_addr == bus.cm_addr));
  assign cnt_inc  = ren_ok && !busy_q[bus.ren_addr];

  always_comb begin
    cnt_next = cnt_q;
    if (bus.flush) begin
      cnt_next = '0;
    end else if (cnt_inc && !cm_clear) begin
      cnt_next = cnt_q + CW'(1);
    end else if (!cnt_inc && cm_clear) begin
      cnt_next = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else if (bus.rdy) begin
      if (cm_ok) begin
        data_q[bus.cm_addr] <= bus.cm_data;
      end
      if (bus.flush) begin
        busy_q <= '0;
      end else begin
        if (cm_clear) begin
          busy_q[bus.cm_addr] <= 1'b0;
        end
        if (ren_ok) begin
          busy_q[bus.ren_addr] <= 1'b1;
          tag_q[bus.ren_addr]  <= bus.ren_tag;
        end
      end
      cnt_q <= cnt_next;
    end
  end

  assign bus.busy_cnt = cnt_q;

  // Reads see stored state plus the commit on the bus, regardless of rdy.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    logic          hit_match;

    assign a         = bus.rd_addr[k*AW +: AW];
    assign hit       = bus.cm_en && (bus.cm_addr == a);
    assign hit_match = hit && busy_q[a] && (tag_q[a] == bus.cm_tag);

    assign bus.rd_data[k*XLEN +: XLEN]   = (a == '0) ? '0 : (hit ? bus.cm_data : data_q[a]);
    assign bus.rd_busy[k]                = (a != '0) && busy_q[a] && !hit_match;
    assign bus.rd_tag[k*TAG_W +: TAG_W]  = (a == '0) ? '0 : tag_q[a];
  end
endmodule

// File: tb/tb_regstat_file.sv
// Directed, table-driven bench for regstat_file plus hand-written reset sequence.
module tb_regstat_file;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int TAG_W = 4;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  typedef struct {
    logic        rdy;
    logic        ren_en;
    logic [4:0]  ren_a;
    logic [3:0]  ren_t;
    logic        cm_en;
    logic [4:0]  cm_a;
    logic [3:0]  cm_t;
    logic [31:0] cm_d;
    logic        flush;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_d0;
    logic        e_b0;
    logic [3:0]  e_t0;
    logic [31:0] e_d1;
    logic        e_b1;
    logic [5:0]  e_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  vec_t vecs [27];

  regstat_if #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NRD(NRD)) bus ();

  regstat_file #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NRD(NRD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic rdy, logic ren_en, logic [4:0] ren_a, logic [3:0] ren_t,
                              logic cm_en, logic [4:0] cm_a, logic [3:0] cm_t, logic [31:0] cm_d,
                              logic flush, logic [4:0] ra0, logic [4:0] ra1,
                              logic [31:0] e_d0, logic e_b0, logic [3:0] e_t0,
                              logic [31:0] e_d1, logic e_b1, logic [5:0] e_cnt);
    vec_t v;
    v.rdy = rdy; v.ren_en = ren_en; v.ren_a = ren_a; v.ren_t = ren_t;
    v.cm_en = cm_en; v.cm_a = cm_a; v.cm_t = cm_t; v.cm_d = cm_d;
    v.flush = flush; v.ra0 = ra0; v.ra1 = ra1;
    v.e_d0 = e_d0; v.e_b0 = e_b0; v.e_t0 = e_t0;
    v.e_d1 = e_d1; v.e_b1 = e_b1; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus.rdy      = v.rdy;
    bus.ren_en   = v.ren_en;
    bus.ren_addr = v.ren_a;
    bus.ren_tag  = v.ren_t;
    bus.cm_en    = v.cm_en;
    bus.cm_addr  = v.cm_a;
    bus.cm_tag   = v.cm_t;
    bus.cm_data  = v.cm_d;
    bus.flush    = v.flush;
    bus.rd_addr  = {v.ra1, v.ra0};
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    vec_t idle;
    //           rdy ren a  t  cm  a  t  data         fl ra0 ra1 ed0          eb0 et0 ed1          eb1 cnt
    vecs[0]  = mk(1, 0, 0, 0, 1, 5, 0, 32'hDEAD,    0, 5,  0,  32'hDEAD,    0, 0,  32'h0,       0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,       0, 5,  1,  32'hDEAD,    0, 0,  32'h0,       0, 0);
    vecs[2]  = mk(1, 1, 3, 7, 0, 0, 0, 32'h0,       0, 3,  5,  32'h0,       0, 0,  32'hDEAD,    0, 1);
    vecs[3]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,       0, 3,  3,  32'h0,       1, 7,  32'h0,       1, 1);
    vecs[4]  = mk(1, 0, 0, 0, 1, 3, 7, 32'h1234,    0, 3,  3,  32'h1234,    0, 7,  32'h1234,    0, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,       0, 3,  3,  32'h1234,    0, 7,  32'h1234,    0, 0);
    vecs[6]  = mk(1, 1, 3, 2, 0, 0, 0, 32'h0,       0, 3,  5,  32'h1234,    0, 7,  32'hDEAD,    0, 1);
    vecs[7]  = mk(1, 1, 3, 5, 0, 0, 0, 32'h0,       0, 3,  3,  32'h1234,    1, 2,  32'h1234,    1, 1);
    vecs[8]  = mk(1, 0, 0, 0, 1, 3, 2, 32'hAA,      0, 3,  3,  32'hAA,      1, 5,  32'hAA,      1, 1);
    vecs[9]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,       0, 3,  3,  32'hAA,      1, 5,  32'hAA,      1, 1);
    vecs[10] = mk(1, 1, 4, 1, 0, 0, 0, 32'h0,       0, 4,  3,  32'h0,       0, 0,  32'hAA,      1, 2);
    vecs[11] = mk(1, 1, 4, 9, 1, 4, 1, 32'h77,      0, 4,  3,  32'h77,      0, 1,  32'hAA,      1, 2);
    vecs[12] = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,       0, 4,  4,  32'h77,      1, 9,  32'h77,      1, 2);
    vecs[13] = mk(1, 1, 6, 3, 0, 0, 0, 32'h0,       0, 6,  4,  32'h0,       0, 0,  32'h77,      1, 3);
    vecs[14] = mk(1, 1, 7, 4, 1, 6, 8, 32'h55,      1, 6,  7,  32'h55,      1, 3,  32'h0,       0, 0);
    vecs[15] = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,       0, 7,  6,  32'h0,       0, 0,  32'h55,      0, 0);
    vecs[16] = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,       0, 0,  4,  32'h0,       0, 0,  32'h77,      0, 0);
    vecs[17] = mk(1, 1, 0, 6, 1, 0, 0, 32'hFF,      0, 0,  0,  32'h0,       0, 0,  32'h0,       0, 0);
    vecs[18] = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,       0, 0,  3,  32'h0,       0, 0,  32'hAA,      0, 0);
    vecs[19] = mk(0, 1, 8, 2, 0, 0, 0, 32'h0,       0, 8,  6,  32'h0,       0, 0,  32'h55,      0, 0);
    vecs[20] = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,       0, 8,  8,  32'h0,       0, 0,  32'h0,       0, 0);
    vecs[21] = mk(0, 0, 0, 0, 1, 9, 0, 32'h99,      0, 9,  9,  32'h99,      0, 0,  32'h99,      0, 0);
    vecs[22] = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,       0, 9,  9,  32'h0,       0, 0,  32'h0,       0, 0);
    vecs[23] = mk(1, 1, 10, 1, 0, 0, 0, 32'h0,      0, 10, 9,  32'h0,       0, 0,  32'h0,       0, 1);
    vecs[24] = mk(0, 0, 0, 0, 1, 10, 1, 32'h5,      0, 10, 10, 32'h5,       0, 1,  32'h5,       0, 1);
    vecs[25] = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,       0, 10, 10, 32'h0,       1, 1,  32'h0,       1, 1);
    vecs[26] = mk(1, 0, 0, 0, 1, 10, 1, 32'h5,      0, 10, 10, 32'h5,       0, 1,  32'h5,       0, 0);

    idle = mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 5, 3, 32'h0, 0, 0, 32'h0, 0, 0);
    applyStimulus(idle);
    #1;
    checkOutput("reset_data_x5", bus.rd_data[31:0], 32'h0);
    checkOutput("reset_cnt", 32'(bus.busy_cnt), 32'h0);
    checkOutput("reset_busy", 32'(bus.rd_busy), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_data0", i), bus.rd_data[31:0], vecs[i].e_d0);
      checkOutput($sformatf("v%0d_busy0", i), 32'(bus.rd_busy[0]), 32'(vecs[i].e_b0));
      checkOutput($sformatf("v%0d_tag0", i), 32'(bus.rd_tag[3:0]), 32'(vecs[i].e_t0));
      checkOutput($sformatf("v%0d_data1", i), bus.rd_data[63:32], vecs[i].e_d1);
      checkOutput($sformatf("v%0d_busy1", i), 32'(bus.rd_busy[1]), 32'(vecs[i].e_b1));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_cnt", i), 32'(bus.busy_cnt), 32'(vecs[i].e_cnt));
    end

    // Asynchronous reset asserted in the middle of a cycle.
    @(negedge clk);
    applyStimulus(idle);
    bus.ren_en   = 1'b1;
    bus.ren_addr = 5'd3;
    bus.ren_tag  = 4'd1;
    @(posedge clk);
    #1;
    bus.ren_en = 1'b0;
    checkOutput("pre_rst_cnt", 32'(bus.busy_cnt), 32'd1);
    checkOutput("pre_rst_busy_x3", 32'(bus.rd_busy[1]), 32'd1);
    checkOutput("pre_rst_data_x5", bus.rd_data[31:0], 32'hDEAD);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_data_x5", bus.rd_data[31:0], 32'h0);
    checkOutput("rst_cnt", 32'(bus.busy_cnt), 32'h0);
    checkOutput("rst_busy", 32'(bus.rd_busy), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_data_x5", bus.rd_data[31:0], 32'h0);
    checkOutput("rst_hold_cnt", 32'(bus.busy_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_cnt", 32'(bus.busy_cnt), 32'h0);
    checkOutput("post_rst_busy", 32'(bus.rd_busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
